// File: rtl/adder_pkg.sv
// -----------------------------------------------------------------------------
// adder_pkg
// Shared constants for the byte-serial 32-bit adder: slice geometry, FSM state
// encodings and a byte-select helper used to feed the shared adder slice.
// -----------------------------------------------------------------------------
package adder_pkg;

    localparam int SLICE_W = 8;
    localparam int NSLICE  = 4;
    localparam int DATA_W  = SLICE_W * NSLICE;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ADD  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    // Select byte `sel` of a 32-bit word (byte 0 = bits 7:0).
    function automatic logic [SLICE_W-1:0] byte_of(input logic [DATA_W-1:0] word,
                                                    input logic [1:0]        sel);
        return word[{sel, 3'b000} +: SLICE_W];
    endfunction

endpackage

// File: rtl/byte_serial_adder32_rca8.sv
// -----------------------------------------------------------------------------
// RCA8
// 8-bit ripple-carry adder slice, time-shared by byte_serial_adder32.
// Ports:
//   A_8, B_8 : 8-bit operands
//   Cin      : carry into bit 0
//   S_8      : 8-bit sum
//   Cout     : carry out of bit 7
// -----------------------------------------------------------------------------
module RCA8 (
    input  logic [7:0] A_8,
    input  logic [7:0] B_8,
    input  logic       Cin,
    output logic [7:0] S_8,
    output logic       Cout
);

    logic ripple;

    // The carry is carried through a single variable bit by bit, which keeps
    // the chain explicit as a ripple rather than a vector self-dependency.
    always_comb begin
        ripple = Cin;
        S_8    = '0;
        for (int i = 0; i < 8; i++) begin
            S_8[i] = A_8[i] ^ B_8[i] ^ ripple;
            ripple = (A_8[i] & B_8[i]) | (ripple & (A_8[i] ^ B_8[i]));
        end
        Cout = ripple;
    end

endmodule

// File: rtl/byte_serial_adder32.sv
// -----------------------------------------------------------------------------
// byte_serial_adder32
// Byte-serial 32-bit adder: one shared 8-bit ripple slice processes one byte per
// cycle over four cycles, giving one result every five cycles.
//
// Build option:
//   BYTE_SERIAL_ADDER_OVF_EN  defined   -> signed overflow is computed and
//                                          registered when entering DONE.
//                             undefined -> overflow is tied to 0.
//
// Ports:
//   clk       : clock, rising edge
//   reset     : synchronous, active-high reset
//   start     : operation request, accepted in IDLE or DONE
//   augend    : operand A, captured on accepted start
//   addend    : operand B, captured on accepted start
//   cin       : carry into bit 0, captured on accepted start
//   busy      : high while a byte is being added
//   done      : one-cycle pulse, result valid
//   sum       : 32-bit result, holds until the next accepted start
//   cout      : carry out of bit 31
//   overflow  : signed two's-complement overflow
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | waiting for start; outputs hold the last result
// ADD    | slice idx (0..3) being added and written into sum
// DONE   | result presented for one cycle; start chains a new operation
// 2'd3   | illegal; returns to IDLE on the next edge
// -----------------------------------------------------------------------------
module byte_serial_adder32
    import adder_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] augend,
    input  logic [DATA_W-1:0] addend,
    input  logic              cin,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] sum,
    output logic              cout,
    output logic              overflow
);

    logic [1:0]         state;
    logic [1:0]         state_nxt;
    logic [1:0]         idx;
    logic               carry;
    logic [DATA_W-1:0]  a_q;
    logic [DATA_W-1:0]  b_q;

    logic [SLICE_W-1:0] slice_a;
    logic [SLICE_W-1:0] slice_b;
    logic [SLICE_W-1:0] slice_s;
    logic               slice_c;

    logic               accept;
    logic               last_byte;

    assign busy      = (state == S_ADD);
    assign done      = (state == S_DONE);
    assign accept    = start && ((state == S_IDLE) || (state == S_DONE));
    assign last_byte = (state == S_ADD) && (idx == 2'd3);

    assign slice_a = byte_of(a_q, idx);
    assign slice_b = byte_of(b_q, idx);

    RCA8 u_rca8 (
        .A_8  (slice_a),
        .B_8  (slice_b),
        .Cin  (carry),
        .S_8  (slice_s),
        .Cout (slice_c)
    );

    always_comb begin
        state_nxt = S_IDLE;
        case (state)
            S_IDLE:  state_nxt = start ? S_ADD : S_IDLE;
            S_ADD:   state_nxt = (idx == 2'd3) ? S_DONE : S_ADD;
            S_DONE:  state_nxt = start ? S_ADD : S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            idx   <= 2'd0;
            carry <= 1'b0;
            a_q   <= '0;
            b_q   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                a_q   <= augend;
                b_q   <= addend;
                carry <= cin;
                idx   <= 2'd0;
                sum   <= '0;
            end else if (state == S_ADD) begin
                sum[{idx, 3'b000} +: SLICE_W] <= slice_s;
                carry <= slice_c;
                idx   <= idx + 2'd1;
                if (last_byte) begin
                    cout <= slice_c;
                end
            end
        end
    end

`ifdef BYTE_SERIAL_ADDER_OVF_EN
    logic ovf_q;

    // The sign bit of the result is produced by the last slice in the same
    // cycle, so take it from the slice output rather than the sum register.
    always_ff @(posedge clk) begin
        if (reset) begin
            ovf_q <= 1'b0;
        end else if (last_byte) begin
            ovf_q <= (a_q[DATA_W-1] == b_q[DATA_W-1]) && (slice_s[SLICE_W-1] != a_q[DATA_W-1]);
        end
    end

    assign overflow = ovf_q;
`else
    assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_byte_serial_adder32.sv
module tb_byte_serial_adder32;

    logic        clk;
    logic        reset;
    logic        start;
    logic [31:0] augend;
    logic [31:0] addend;
    logic        cin;
    logic        busy;
    logic        done;
    logic [31:0] sum;
    logic        cout;
    logic        overflow;

    int checks = 0;
    int errors = 0;

`ifdef BYTE_SERIAL_ADDER_OVF_EN
    localparam logic OVF = 1'b1;
`else
    localparam logic OVF = 1'b0;
`endif

    byte_serial_adder32 dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .augend   (augend),
        .addend   (addend),
        .cin      (cin),
        .busy     (busy),
        .done     (done),
        .sum      (sum),
        .cout     (cout),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        ci;
        logic [31:0] exp_sum;
        logic        exp_cout;
        logic        exp_ovf;
    } vec_t;

    localparam int NV = 8;
    vec_t vecs [NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Runs one operation from an IDLE/DONE-free start. Operand inputs are
    // scrambled after capture; optional re-pulse of start during busy.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic ci,
                          input logic [31:0] es, input logic ec, input logic eo,
                          input int repulse_at, input string tag);
        int          busy_cnt;
        int          done_cnt;
        int          first_done;
        logic [31:0] s_done;
        logic        c_done;
        logic        o_done;
        busy_cnt = 0; done_cnt = 0; first_done = 0;
        s_done = '0; c_done = 1'b0; o_done = 1'b0;
        @(negedge clk);
        augend = a; addend = b; cin = ci; start = 1'b1;
        @(posedge clk);
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk);
            if (n == 1) begin
                start = 1'b0; augend = ~a; addend = a ^ b; cin = ~ci;
            end
            if (repulse_at != 0 && n == repulse_at) begin
                start = 1'b1; augend = 32'hFFFF_FFFF; addend = 32'hFFFF_FFFF;
            end
            if (repulse_at != 0 && n == repulse_at + 1) start = 1'b0;
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                if (first_done == 0) begin
                    first_done = n; s_done = sum; c_done = cout; o_done = overflow;
                end
            end
        end
        chk($sformatf("%s.done_cycle", tag), first_done, 5);
        chk($sformatf("%s.busy_cycles", tag), busy_cnt, 4);
        chk($sformatf("%s.done_pulses", tag), done_cnt, 1);
        chk($sformatf("%s.sum", tag), s_done, es);
        chk($sformatf("%s.cout", tag), {31'd0, c_done}, {31'd0, ec});
        chk($sformatf("%s.ovf", tag), {31'd0, o_done}, {31'd0, eo});
        chk($sformatf("%s.sum_hold", tag), sum, es);
    endtask

    initial begin
        int first_done;
        int done_cnt;

        vecs[0] = '{32'h0000_00FF, 32'h0000_0001, 1'b0, 32'h0000_0100, 1'b0, 1'b0};
        vecs[1] = '{32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1, 1'b0};
        vecs[2] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, OVF};
        vecs[3] = '{32'h1234_5678, 32'h1111_1111, 1'b0, 32'h2345_6789, 1'b0, 1'b0};
        vecs[4] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, OVF};
        vecs[5] = '{32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
        vecs[6] = '{32'h00FF_00FF, 32'h0001_0001, 1'b1, 32'h0100_0101, 1'b0, 1'b0};
        vecs[7] = '{32'h4000_0000, 32'h4000_0000, 1'b0, 32'h8000_0000, 1'b0, OVF};

        reset = 1'b1; start = 1'b0; augend = '0; addend = '0; cin = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst.busy", {31'd0, busy}, 32'd0);
        chk("rst.done", {31'd0, done}, 32'd0);
        chk("rst.sum", sum, 32'd0);
        chk("rst.cout", {31'd0, cout}, 32'd0);
        chk("rst.ovf", {31'd0, overflow}, 32'd0);
        reset = 1'b0;

        for (int i = 0; i < NV; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].ci, vecs[i].exp_sum,
                   vecs[i].exp_cout, vecs[i].exp_ovf, 0, $sformatf("vec%0d", i));
        end

        // start re-pulsed during the 2nd busy cycle must be ignored
        run_op(32'h1234_5678, 32'h1111_1111, 1'b0, 32'h2345_6789, 1'b0, 1'b0, 2, "ignore");

        // reset during the 3rd ADD cycle
        @(negedge clk);
        augend = 32'hFFFF_FFFF; addend = 32'h0000_0001; cin = 1'b0; start = 1'b1;
        @(posedge clk);
        done_cnt = 0;
        for (int n = 1; n <= 8; n++) begin
            @(negedge clk);
            if (n == 1) start = 1'b0;
            if (done) done_cnt++;
            if (n == 3) begin
                chk("midrst.busy_before", {31'd0, busy}, 32'd1);
                reset = 1'b1;
            end
            if (n == 4) begin
                reset = 1'b0;
                chk("midrst.busy", {31'd0, busy}, 32'd0);
                chk("midrst.done", {31'd0, done}, 32'd0);
                chk("midrst.sum", sum, 32'd0);
            end
        end
        chk("midrst.no_done", done_cnt, 0);
        run_op(32'h0000_0002, 32'h0000_0003, 1'b0, 32'h0000_0005, 1'b0, 1'b0, 0, "post_rst");

        // back-to-back: start held high through DONE
        @(negedge clk);
        augend = 32'h0000_0001; addend = 32'h0000_0002; cin = 1'b0; start = 1'b1;
        @(posedge clk);
        first_done = 0; done_cnt = 0;
        for (int n = 1; n <= 14; n++) begin
            @(negedge clk);
            if (n == 1) start = 1'b0;
            if (n == 4) begin
                start = 1'b1; augend = 32'h0000_0010; addend = 32'h0000_0020;
            end
            if (n == 5) begin
                chk("b2b.first_done", {31'd0, done}, 32'd1);
                chk("b2b.first_sum", sum, 32'h0000_0003);
            end
            if (n == 6) begin
                start = 1'b0; augend = 32'hDEAD_BEEF; addend = 32'h1234_5678;
                chk("b2b.rebusy", {31'd0, busy}, 32'd1);
            end
            if (n > 5 && done) begin
                done_cnt++;
                if (first_done == 0) first_done = n;
            end
        end
        chk("b2b.second_done_cycle", first_done, 10);
        chk("b2b.second_pulses", done_cnt, 1);
        chk("b2b.second_sum", sum, 32'h0000_0030);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/byte_serial_adder32.md
# byte_serial_adder32

Byte-serial 32-bit add controller. It time-shares a single 8-bit ripple-carry slice across four cycles to produce a 32-bit sum, carry-out and optional signed overflow. It sits beside the combinational 32-bit adder as the area-reduced alternative, used where one add every five cycles is sufficient. A start/busy/done handshake sequences operand capture, per-byte carry propagation and result presentation.

## Interface
- SLICE_W, 8: width of the shared adder slice; fixed at 8 in this revision.
- NSLICE, 4: number of slices per word; data width is SLICE_W*NSLICE = 32.
- clk  input  1  single clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only while busy=0.
- augend  input  32  operand A; captured on an accepted start.
- addend  input  32  operand B; captured on an accepted start.
- cin  input  1  carry-in to bit 0; captured on an accepted start.
- busy  output  1  high while a byte is being added (state ADD).
- done  output  1  one-cycle pulse; sum, cout and overflow are valid.
- sum  output  32  result; holds its value until the next accepted start.
- cout  output  1  carry out of bit 31.
- overflow  output  1  signed two's-complement overflow.

## Operation
- States:
  - IDLE: busy=0, done=0.
  - ADD: busy=1, done=0; 2-bit slice index idx runs 0..3.
  - DONE: busy=0, done=1.
- IDLE, start=1 -> ADD:
  - Latch augend, addend and cin.
  - idx=0; carry register = cin; clear sum to 0.
- ADD, each cycle:
  - Slice adds A[8*idx+7:8*idx] + B[8*idx+7:8*idx] + carry.
  - The result byte is written to sum[8*idx+7:8*idx].
  - The slice carry-out loads the carry register.
  - idx increments. When idx=3, the next state is DONE.
- DONE:
  - cout = final carry.
  - overflow per Configuration.
  - start=1 -> ADD with new operands (back-to-back). Otherwise -> IDLE.
- start while busy=1: ignored. No queuing, and latched operands are unaffected.
- Changes on augend/addend/cin after capture: no effect on the operation in flight.
- Arithmetic is modulo 2^32. No saturation.
- Reset, including mid-operation, takes effect at the next edge:
  - state=IDLE, idx=0, carry=0.
  - sum=0, cout=0, overflow=0, busy=0, done=0.
  - The partial result is discarded.

## Timing
- Reset values: busy=0, done=0, sum=32'h0, cout=0, overflow=0.
- Start sampled high at edge E0 (IDLE or DONE):
  - busy=1 after E0.
  - Bytes 0..3 are registered at edges E1..E4.
  - done=1 after E4, for exactly one cycle.
- Latency from accepted start to done is 5 cycles. Back-to-back throughput is one result per 5 cycles.
- sum bytes update progressively while busy=1. sum is only guaranteed coherent while done=1, and afterwards until the next accepted start.
- cout and overflow update only at the edge entering DONE. They hold until the next accepted start or reset.

## Configuration
- BYTE_SERIAL_ADDER_OVF_EN defined:
  - overflow = (A[31]==B[31]) && (sum[31]!=A[31]), registered entering DONE.
  - Uses the latched operands.
- Not defined:
  - overflow is tied to 0.
  - No overflow logic is synthesized.
  - The port remains present.

## Structure
- Package/header adder_pkg holds:
  - SLICE_W, NSLICE.
  - State encodings S_IDLE=2'd0, S_ADD=2'd1, S_DONE=2'd2.
- The remaining encoding 2'd3 is illegal and recovers to IDLE on the next edge.
- Sub-module: exactly one instance of the existing 8-bit ripple-carry slice RCA8. Its ports are A_8, B_8, Cin, Cout, S_8, and it is driven through idx-selected byte muxes.
- The FSM, index counter, operand registers and carry register are local to this block.

## Test plan
- 0x000000FF + 0x00000001, cin=0:
  - done at the 5th edge after start: sum=0x00000100, cout=0, overflow=0.
  - busy high for exactly 4 cycles.
- 0xFFFFFFFF + 0x00000000, cin=1:
  - sum=0x00000000, cout=1, overflow=0.
  - Carry ripples through all four bytes.
- 0x7FFFFFFF + 0x00000001:
  - sum=0x80000000, cout=0.
  - overflow=1 with BYTE_SERIAL_ADDER_OVF_EN defined, 0 without.
- Start 0x12345678 + 0x11111111, then re-pulse start with 0xFFFFFFFF+0xFFFFFFFF during the 2nd busy cycle:
  - Second request ignored; sum=0x23456789, single done pulse.
- Reset asserted during the 3rd ADD cycle, then start 0x00000002 + 0x00000003:
  - After reset: busy=0, done=0, sum=0 with no done pulse.
  - Then sum=0x00000005 after 5 cycles.
- Start held high through DONE with new operands 0x00000010 + 0x00000020:
  - The second operation begins immediately.
  - Second done 5 cycles after the first, sum=0x00000030.
